// File: rtl/uart_pkg.sv
// Shared definitions for the 3x-oversampled UART transmit path: parity modes,
// serialiser states and the frame length helper.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP,
        TX_BREAK
    } tx_state_e;

    // Sampler ticks taken by one complete frame, start bit through last stop bit.
    function automatic int unsigned frame_len(
        input int unsigned oversample,
        input int unsigned data_bits,
        input int unsigned parity,
        input int unsigned stop_bits
    );
        int unsigned par_bits;
        par_bits = (parity != PAR_NONE) ? 32'd1 : 32'd0;
        return oversample * (32'd1 + data_bits + par_bits + stop_bits);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous holding FIFO in front of the serialiser; pointers wrap
// naturally because DEPTH is a power of two.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     rx_sampler_clk,
    input  logic                     rx_sampler_reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge rx_sampler_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge rx_sampler_clk or negedge rx_sampler_reset) begin
        if (!rx_sampler_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_x3.sv
// UART transmitter clocked by the RX oversampling clock: every bit lasts exactly
// OVERSAMPLE ticks so echoed frames line up with the receive sampler.
module uart_tx_x3
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 3,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 rx_sampler_clk,
    input  logic                 rx_sampler_reset,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    input  logic                 tx_break_i,
    output logic                 tx_o,
    output logic                 tx_busy_o,
    output logic                 tx_done_o
);

    localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W      = 4;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FRAME_BITS = frame_len(OVERSAMPLE, DATA_BITS, PARITY, STOP_BITS) / OVERSAMPLE;

    tx_state_e            state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 brk_q;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 line_busy_q;
    logic                 last_tick;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign fifo_push  = tx_valid_i && tx_ready_o;
    assign tx_ready_o = !fifo_full;
    assign tx_o       = tx_q;
    assign tx_done_o  = done_q;
    assign tx_busy_o  = (state_q != TX_IDLE) || (fifo_count != '0) || line_busy_q;
    assign last_tick  = (tick_q == TICK_W'(OVERSAMPLE - 1));

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .rx_sampler_clk   (rx_sampler_clk),
        .rx_sampler_reset (rx_sampler_reset),
        .push             (fifo_push),
        .push_data        (tx_data_i),
        .pop              (fifo_pop),
        .pop_data         (fifo_rd_data),
        .count            (fifo_count),
        .full             (fifo_full),
        .empty            (fifo_empty)
    );

    always_ff @(posedge rx_sampler_clk or negedge rx_sampler_reset) begin
        if (!rx_sampler_reset) begin
            state_q     <= TX_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            brk_q       <= 1'b0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
            line_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
            line_busy_q <= (state_q != TX_IDLE);
            if (fifo_pop) begin
                shift_q <= fifo_rd_data;
                par_q   <= (PARITY == PAR_EVEN) ? ^fifo_rd_data : ~^fifo_rd_data;
            end else if ((state_q == TX_DATA) && last_tick) begin
                shift_q <= shift_q >> 1;
            end
            // Remembers that the current STOP is the mark after a break, which must not raise tx_done_o.
            if (state_q == TX_BREAK) begin
                brk_q <= 1'b1;
            end else if (fifo_pop) begin
                brk_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        fifo_pop = 1'b0;
        tx_d     = 1'b1;
        done_d   = 1'b0;

        if (state_q != TX_IDLE) begin
            tick_d = last_tick ? '0 : tick_q + 1'b1;
        end

        unique case (state_q)
            TX_IDLE: begin
                bit_d = '0;
                if (tx_break_i) begin
                    state_d = TX_BREAK;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = TX_START;
                end
            end
            TX_START: begin
                tx_d = 1'b0;
                if (last_tick) begin
                    state_d = TX_DATA;
                    bit_d   = '0;
                end
            end
            TX_DATA: begin
                tx_d = shift_q[0];
                if (last_tick) begin
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                tx_d = par_q;
                if (last_tick) begin
                    state_d = TX_STOP;
                    bit_d   = '0;
                end
            end
            TX_STOP: begin
                if (last_tick) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        done_d = !brk_q;
                        bit_d  = '0;
                        // Popping on the final tick lets the next start bit follow with no idle gap.
                        if (tx_break_i) begin
                            state_d = TX_BREAK;
                        end else if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            state_d  = TX_START;
                        end else begin
                            state_d = TX_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            TX_BREAK: begin
                tx_d = 1'b0;
                // Bit counter saturates at one frame so a short request still yields a full-frame break.
                if (last_tick) begin
                    if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                        if (!tx_break_i) begin
                            state_d = TX_STOP;
                            bit_d   = '0;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_x3.sv
// Bench for uart_tx_x3: the line is compared cycle by cycle against a frame
// waveform built from the framing rules; three parity variants run side by side.
module tb_uart_tx_x3;

    localparam int unsigned OS = 3;

    logic       clk;
    logic       rst_n;
    logic [2:0] valid;
    logic [2:0] brk;
    logic [2:0] ready;
    logic [2:0] txo;
    logic [2:0] busy;
    logic [2:0] done;
    logic [7:0] data_s [3];

    int checks = 0;
    int errors = 0;

    bit         exp_wave[$];
    logic [7:0] stim_q[$];

    uart_tx_x3 dut0 (
        .rx_sampler_clk (clk), .rx_sampler_reset (rst_n),
        .tx_data_i (data_s[0]), .tx_valid_i (valid[0]), .tx_ready_o (ready[0]),
        .tx_break_i (brk[0]), .tx_o (txo[0]), .tx_busy_o (busy[0]), .tx_done_o (done[0])
    );

    uart_tx_x3 #(.PARITY(1)) dut1 (
        .rx_sampler_clk (clk), .rx_sampler_reset (rst_n),
        .tx_data_i (data_s[1]), .tx_valid_i (valid[1]), .tx_ready_o (ready[1]),
        .tx_break_i (brk[1]), .tx_o (txo[1]), .tx_busy_o (busy[1]), .tx_done_o (done[1])
    );

    uart_tx_x3 #(.PARITY(2)) dut2 (
        .rx_sampler_clk (clk), .rx_sampler_reset (rst_n),
        .tx_data_i (data_s[2]), .tx_valid_i (valid[2]), .tx_ready_o (ready[2]),
        .tx_break_i (brk[2]), .tx_o (txo[2]), .tx_busy_o (busy[2]), .tx_done_o (done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line for one frame: start 0, data LSB first, optional parity, one stop 1.
    function automatic void add_frame(input logic [7:0] d, input int par);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (par == 2) bits.push_back(^d);
        else if (par == 1) bits.push_back(~^d);
        bits.push_back(1'b1);
        foreach (bits[i])
            for (int r = 0; r < int'(OS); r++) exp_wave.push_back(bits[i]);
    endfunction

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            checks++; if (txo[s] !== 1'b1)  begin errors++; $display("FAIL reset_tx dut%0d: got %b want 1", s, txo[s]); end
            checks++; if (ready[s] !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d: got %b want 1", s, ready[s]); end
            checks++; if (busy[s] !== 1'b0)  begin errors++; $display("FAIL reset_busy dut%0d: got %b want 0", s, busy[s]); end
            checks++; if (done[s] !== 1'b0)  begin errors++; $display("FAIL reset_done dut%0d: got %b want 0", s, done[s]); end
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (txo[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: tx=%b busy=%b want tx=1 busy=0", txo[0], busy[0]);
        end
    endtask

    // Pushes stim_q back to back and checks line, done and ready on every cycle.
    task automatic test_stream(input string name, input int sel, input int par);
        logic [7:0]  pend[$];
        int unsigned pop_edge[$];
        int unsigned done_cyc[$];
        int unsigned total, n, acc;
        int          cnt;
        logic        wp, exp_tx, exp_done, exp_rdy;
        exp_wave.delete();
        pend = stim_q;
        acc = 1;
        foreach (stim_q[i]) begin
            pop_edge.push_back(acc);
            add_frame(stim_q[i], par);
            acc = 1 + exp_wave.size();
            done_cyc.push_back(acc);
        end
        total = exp_wave.size();
        n = total + 3;
        cnt = 0;
        valid[sel] = 1'b1;
        data_s[sel] = pend[0];
        wp = ready[sel];
        for (int unsigned k = 0; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (wp) begin void'(pend.pop_front()); cnt++; end
            if (pop_edge.size() > 0 && pop_edge[0] == k) begin void'(pop_edge.pop_front()); cnt--; end
            exp_tx = (k >= 2 && k - 2 < total) ? exp_wave[k-2] : 1'b1;
            exp_done = (done_cyc.size() > 0 && done_cyc[0] == k);
            if (exp_done) void'(done_cyc.pop_front());
            exp_rdy = (cnt < 2);
            checks++; if (txo[sel] !== exp_tx) begin errors++; $display("FAIL %s_tx cycle %0d: got %b want %b", name, k, txo[sel], exp_tx); end
            checks++; if (done[sel] !== exp_done) begin errors++; $display("FAIL %s_done cycle %0d: got %b want %b", name, k, done[sel], exp_done); end
            checks++; if (ready[sel] !== exp_rdy) begin errors++; $display("FAIL %s_ready cycle %0d: got %b want %b", name, k, ready[sel], exp_rdy); end
            if (k == 2) begin
                checks++; if (busy[sel] !== 1'b1) begin errors++; $display("FAIL %s_busy_mid: got %b want 1", name, busy[sel]); end
            end
            if (k == n) begin
                checks++; if (busy[sel] !== 1'b0) begin errors++; $display("FAIL %s_busy_end: got %b want 0", name, busy[sel]); end
            end
            if (pend.size() > 0) begin valid[sel] = 1'b1; data_s[sel] = pend[0]; end
            else valid[sel] = 1'b0;
            wp = valid[sel] && ready[sel];
        end
        valid[sel] = 1'b0;
        checks++; if (pend.size() != 0) begin errors++; $display("FAIL %s_accept: %0d words left want 0", name, pend.size()); end
    endtask

    task automatic test_single_frame();
        stim_q = '{8'h55};
        test_stream("frame55", 0, 0);
        for (int i = 0; i < 3; i++) begin
            stim_q = '{8'($urandom)};
            test_stream("frame_rand", 0, 0);
        end
    endtask

    task automatic test_parity();
        stim_q = '{8'hC3};
        test_stream("even_c3", 2, 2);
        stim_q = '{8'h81};
        test_stream("odd_81", 1, 1);
        stim_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
        test_stream("even_rand", 2, 2);
        stim_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
        test_stream("odd_rand", 1, 1);
    endtask

    task automatic test_back_to_back();
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        test_stream("b2b", 0, 0);
        stim_q = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        test_stream("b2b_rand", 0, 0);
    endtask

    task automatic test_break_idle(input int unsigned hold);
        int unsigned low_len, ndone, exp_min, win;
        bit rose, glitch;
        exp_min = (hold > 30) ? hold : 30;
        win = exp_min + OS + 20;
        low_len = 0; ndone = 0; rose = 0; glitch = 0;
        brk[0] = 1'b1;
        for (int unsigned k = 0; k < win; k++) begin
            @(posedge clk);
            #1;
            if (k == hold - 1) brk[0] = 1'b0;
            if (done[0]) ndone++;
            if (txo[0] === 1'b0) begin
                if (rose) glitch = 1;
                low_len++;
            end else if (low_len > 0 && !rose) begin
                rose = 1;
                checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL break_mark_busy: got %b want 1", busy[0]); end
            end
        end
        checks++; if (low_len < exp_min || low_len > exp_min + OS) begin
            errors++; $display("FAIL break_len hold=%0d: got %0d low cycles want %0d..%0d", hold, low_len, exp_min, exp_min + OS);
        end
        checks++; if (glitch) begin errors++; $display("FAIL break_shape: line went low again after mark"); end
        checks++; if (ndone != 0) begin errors++; $display("FAIL break_done: got %0d pulses want 0", ndone); end
        checks++; if (busy[0] !== 1'b0 || txo[0] !== 1'b1) begin
            errors++; $display("FAIL break_end: busy=%b tx=%b want 0/1", busy[0], txo[0]);
        end
    endtask

    task automatic test_break_midframe();
        logic exp_tx;
        bit   idle;
        exp_wave.delete();
        add_frame(8'hA5, 0);
        valid[0] = 1'b1;
        data_s[0] = 8'hA5;
        for (int unsigned k = 0; k <= 40; k++) begin
            @(posedge clk);
            #1;
            valid[0] = 1'b0;
            if (k == 10) brk[0] = 1'b1;
            if (k <= 33) begin
                exp_tx = (k >= 2 && k <= 31) ? exp_wave[k-2] : (k >= 32) ? 1'b0 : 1'b1;
                checks++; if (txo[0] !== exp_tx) begin errors++; $display("FAIL midbrk_tx cycle %0d: got %b want %b", k, txo[0], exp_tx); end
            end
            checks++; if (done[0] !== (k == 31)) begin errors++; $display("FAIL midbrk_done cycle %0d: got %b want %b", k, done[0], k == 31); end
        end
        brk[0] = 1'b0;
        idle = 0;
        for (int k = 0; k < 200 && !idle; k++) begin
            @(posedge clk);
            #1;
            if (busy[0] === 1'b0) idle = 1;
        end
        checks++; if (!idle || txo[0] !== 1'b1) begin
            errors++; $display("FAIL midbrk_idle: idle=%b tx=%b want 1/1 within 200 cycles", idle, txo[0]);
        end
    endtask

    task automatic test_reset_midframe();
        int unsigned bad;
        valid[0] = 1'b1;
        data_s[0] = 8'hE3;
        for (int unsigned k = 0; k <= 18; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) data_s[0] = 8'h5A;
            if (k == 1) valid[0] = 1'b0;
        end
        checks++; if (txo[0] !== 1'b0) begin errors++; $display("FAIL rstmid_bit4: got %b want 0", txo[0]); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (txo[0] !== 1'b1)  begin errors++; $display("FAIL rstmid_tx: got %b want 1", txo[0]); end
        checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", ready[0]); end
        checks++; if (busy[0] !== 1'b0)  begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy[0]); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (txo[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_quiet: %0d active cycles want 0", bad); end
        stim_q = '{8'h3C};
        test_stream("after_rst", 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        valid = '0;
        brk = '0;
        for (int s = 0; s < 3; s++) data_s[s] = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_break_idle(1);
        test_break_idle($urandom_range(35, 60));
        test_break_midframe();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
